// File: rtl/refresh_pkg.sv
// Shared constants and helper functions for the refresh clock generator.
package refresh_pkg;

  localparam int unsigned CLK_HZ_DEF     = 100_000_000;
  localparam int unsigned REFRESH_HZ_DEF = 60;
  localparam int unsigned NUM_DIGITS_DEF = 8;

  // Ceiling log2, minimum 1 bit for any n >= 2.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  // Half-period in clk cycles that yields the requested full-display refresh.
  function automatic int unsigned calc_half(input int unsigned clk_hz,
                                            input int unsigned refresh_hz,
                                            input int unsigned digits);
    return clk_hz / (refresh_hz * digits * 2);
  endfunction

endpackage

// File: rtl/refresh_clk_gen_mod_counter.sv
// Generic modulo-N wrap counter with increment strobe and registered wrap pulse.
module mod_counter #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         wrap_q, wrap_d;
  logic         at_top_c;

  // Next count: step on enabled increment, wrap from N-1 back to 0.
  always_comb begin
    cnt_d    = cnt_q;
    wrap_d   = 1'b0;
    at_top_c = (cnt_q == W'(N - 1));
    if (en_i && inc_i) begin
      if (at_top_c) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  // Count and wrap registers, synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/refresh_clk_gen.sv
// Pixel clock / digit-scan generator for the seven-segment display controller.
// Optional macro REFRESH_ANODE_EN adds the registered active-low anode decode an_n.
module refresh_clk_gen
  import refresh_pkg::*;
#(
  parameter int unsigned CLK_HZ       = CLK_HZ_DEF,
  parameter int unsigned REFRESH_HZ   = REFRESH_HZ_DEF,
  parameter int unsigned NUM_DIGITS   = NUM_DIGITS_DEF,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DEFAULT_HALF = calc_half(CLK_HZ, REFRESH_HZ, NUM_DIGITS),
  localparam int unsigned DIG_W       = clog2(NUM_DIGITS)
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              en,
  input  logic              div_ld,
  input  logic [CNT_W-1:0]  div_val,
  output logic              clk_out,
  output logic              tick,
  output logic [DIG_W-1:0]  digit_sel,
  output logic              frame_start,
  output logic [CNT_W-1:0]  half_cur
`ifdef REFRESH_ANODE_EN
  ,
  output logic [NUM_DIGITS-1:0] an_n
`endif
);

  // Reject configurations that cannot be represented.
  if (NUM_DIGITS < 2) begin : g_chk_digits
    $error("refresh_clk_gen: NUM_DIGITS must be >= 2");
  end
  if (DEFAULT_HALF < 1) begin : g_chk_half_min
    $error("refresh_clk_gen: DEFAULT_HALF must be >= 1");
  end
  if (CNT_W < 32 && 64'(DEFAULT_HALF) >= (64'd1 << CNT_W)) begin : g_chk_half_fit
    $error("refresh_clk_gen: DEFAULT_HALF does not fit in CNT_W");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             bnd_c, rise_c;

  // Half-period boundary and the rising subset of boundaries.
  always_comb begin
    bnd_c  = en && (cnt_q == half_q - CNT_W'(1));
    rise_c = bnd_c && !clk_q;
  end

  // Next state: count/toggle, apply pending divisor only at a boundary.
  always_comb begin
    cnt_d      = cnt_q;
    clk_d      = clk_q;
    tick_d     = 1'b0;
    half_d     = half_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (en) begin
      if (bnd_c) begin
        cnt_d  = '0;
        clk_d  = ~clk_q;
        tick_d = ~clk_q;
        if (pend_vld_q) begin
          half_d     = pend_q;
          pend_vld_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // A load in a boundary cycle lands after that boundary consumed the old state.
    if (div_ld) begin
      pend_d     = (div_val <= CNT_W'(1)) ? CNT_W'(1) : div_val;
      pend_vld_d = 1'b1;
    end
  end

  // Divider state registers, synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt_q      <= '0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
      half_q     <= CNT_W'(DEFAULT_HALF);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
      half_q     <= half_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  mod_counter #(
    .N (NUM_DIGITS),
    .W (DIG_W)
  ) u_digit (
    .clk_i  (clk_in),
    .rst_i  (reset),
    .en_i   (en),
    .inc_i  (rise_c),
    .cnt_o  (digit_sel),
    .wrap_o (frame_start)
  );

  assign clk_out  = clk_q;
  assign tick     = tick_q;
  assign half_cur = half_q;

`ifdef REFRESH_ANODE_EN
  logic [DIG_W-1:0]      dig_nxt_c;
  logic [NUM_DIGITS-1:0] an_q;

  // Digit value the scan counter takes at this edge, so the decode stays aligned.
  always_comb begin
    dig_nxt_c = digit_sel;
    if (rise_c) begin
      dig_nxt_c = (digit_sel == DIG_W'(NUM_DIGITS - 1)) ? '0 : digit_sel + DIG_W'(1);
    end
  end

  // Active-low one-hot anode drive, all off in reset.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      an_q <= '1;
    end else begin
      an_q <= ~(NUM_DIGITS'(1) << dig_nxt_c);
    end
  end

  assign an_n = an_q;
`endif

endmodule

// File: tb/tb_refresh_clk_gen.sv
// Bench for refresh_clk_gen: 1600 Hz clock, 50 Hz refresh, 4 digits (half = 4).
module tb_refresh_clk_gen;

  localparam int unsigned ND = 4;

  logic        clk = 1'b0;
  logic        reset, en, div_ld;
  logic [31:0] div_val;
  logic        clk_out, tick, frame_start;
  logic [1:0]  digit_sel;
  logic [31:0] half_cur;
`ifdef REFRESH_ANODE_EN
  logic [3:0]  an_n;
`endif

  refresh_clk_gen #(
    .CLK_HZ     (1600),
    .REFRESH_HZ (50),
    .NUM_DIGITS (ND),
    .CNT_W      (32)
  ) dut (
    .clk_in      (clk),
    .reset       (reset),
    .en          (en),
    .div_ld      (div_ld),
    .div_val     (div_val),
    .clk_out     (clk_out),
    .tick        (tick),
    .digit_sel   (digit_sel),
    .frame_start (frame_start),
    .half_cur    (half_cur)
`ifdef REFRESH_ANODE_EN
    ,
    .an_n        (an_n)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: time-to-next-toggle plus total rising edges seen.
  bit m_live = 0;
  bit m_inrst;
  bit m_lvl, m_tick, m_fs, m_pv;
  int m_rises, m_half, m_left, m_pend;

  always @(posedge clk) begin
    bit nv;
    if (reset) begin
      m_live = 1; m_inrst = 1;
      m_lvl = 0; m_tick = 0; m_fs = 0; m_rises = 0;
      m_half = 4; m_left = 4; m_pv = 0;
    end else if (m_live) begin
      m_inrst = 0; m_tick = 0; m_fs = 0; nv = m_pv;
      if (en) begin
        m_left--;
        if (m_left == 0) begin
          m_lvl = !m_lvl;
          if (m_lvl) begin
            m_rises++;
            m_tick = 1;
            m_fs = (m_rises % ND == 0);
          end
          if (m_pv) begin
            m_half = m_pend;
            nv = 0;
          end
          m_left = m_half;
        end
      end
      if (div_ld) begin
        m_pend = (div_val < 2) ? 1 : int'(div_val);
        nv = 1;
      end
      m_pv = nv;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_live) begin
      chk("clk_out", clk_out, m_lvl);
      chk("tick", tick, m_tick);
      chk("frame_start", frame_start, m_fs);
      chk("digit_sel", digit_sel, m_rises % ND);
      chk("half_cur", half_cur, m_half);
`ifdef REFRESH_ANODE_EN
      begin
        logic [3:0] oh;
        oh = 4'b0001 << (m_rises % ND);
        chk("an_n", an_n, m_inrst ? 4'hF : {28'd0, ~oh});
      end
`endif
    end
  end

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int nt, nf, guard;
    reset = 1; en = 1; div_ld = 0; div_val = 0;
    step(3);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_digit", digit_sel, 0);
    chk("rst_half", half_cur, 4);
`ifdef REFRESH_ANODE_EN
    chk("rst_an_n", an_n, 4'hF);
`endif
    reset = 0;

    // Free run: 8 rises and 2 frames in 64 cycles.
    nt = 0; nf = 0;
    for (int i = 1; i <= 64; i++) begin
      step();
      nt += int'(tick);
      nf += int'(frame_start);
      if (i == 3) chk("pre_rise_clk", clk_out, 0);
      if (i == 4) begin
        chk("first_rise_clk", clk_out, 1);
        chk("first_rise_tick", tick, 1);
        chk("first_rise_digit", digit_sel, 1);
`ifdef REFRESH_ANODE_EN
        chk("an_n_digit1", an_n, 4'b1101);
`endif
      end
      if (i == 28) chk("wrap_frame_start", frame_start, 1);
    end
    chk("tick_count", nt, 8);
    chk("frame_count", nf, 2);

    // Reload mid-half: old half finishes, then half = 2.
    step();
    div_ld = 1; div_val = 2;
    step();
    div_ld = 0;
    step();
    chk("reload_hold_half", half_cur, 4);
    step();
    chk("reload_new_half", half_cur, 2);
    chk("reload_edge_clk", clk_out, 1);
    step(2);
    chk("half2_clk", clk_out, 0);

    // Load 0 in a boundary cycle: one more half of 2, then clamps to 1.
    step();
    div_ld = 1; div_val = 0;
    step();
    div_ld = 0;
    chk("bnd_load_half", half_cur, 2);
    step(2);
    chk("clamp_half", half_cur, 1);
    chk("clamp_clk0", clk_out, 0);
    step();
    chk("clamp_clk1", clk_out, 1);
    step();
    chk("clamp_clk2", clk_out, 0);

    // Back to 4, then freeze at cnt=2 for 10 cycles.
    div_ld = 1; div_val = 4;
    step();
    div_ld = 0;
    step();
    chk("restore_half", half_cur, 4);
    step(2);
    en = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("frozen_clk", clk_out, 0);
      chk("frozen_tick", tick, 0);
    end
    en = 1;
    step();
    chk("resume_clk1", clk_out, 0);
    step();
    chk("resume_clk2", clk_out, 1);
    chk("resume_tick", tick, 1);
    chk("resume_digit", digit_sel, 1);

    // Mid-frame reset discards a pending divisor.
    guard = 0;
    while (m_rises % ND != 2 && guard < 100) begin
      step();
      guard++;
    end
    chk("reach_digit2_timeout", guard < 100, 1);
    div_ld = 1; div_val = 3;
    step();
    div_ld = 0; reset = 1;
    step();
    chk("midrst_digit", digit_sel, 0);
    chk("midrst_half", half_cur, 4);
    chk("midrst_clk", clk_out, 0);
    reset = 0;
    step(8);
    chk("pend_discarded", half_cur, 4);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 199) == 0);
      en      = ($urandom_range(0, 9) != 0);
      div_ld  = ($urandom_range(0, 29) == 0);
      div_val = $urandom_range(0, 6);
      step();
    end
    reset = 0; div_ld = 0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
